// File: rtl/alu_lockstep_sequencer.sv
// ---------------------------------------------------------------------------
// alu_lockstep_sequencer
//   Issues one operation at a time to a duplicated 8-bit ALU pair, compares the
//   two copies, re-executes on mismatch up to MAX_RETRY times and returns the
//   copy 0 result with a fault flag on a valid/ready response channel.
//
// Optional build macro: ALU_LOCKSTEP_INJECT_EN
//   Adds inj_en / inj_mask. The mask is XORed into the copy 1 result on the
//   compare path only, so lockstep faults can be provoked for self-test.
//
// Ports
//   wb_clk_i, wb_rst_ni         clock, synchronous active-low reset
//   req_valid/ready, req_a/b/sel   request channel
//   alu_a/b/sel                 registered operands to both ALU copies
//   alu0_out/carry, alu1_out/carry results from the two copies
//   resp_valid/ready, resp_data/carry/fault/retries   response channel
//   fault_cnt, fault_sticky, clr_fault   mismatch statistics and clear
//   inj_en, inj_mask            fault injection (macro builds only)
//
// state | meaning
// ------+--------------------------------------------------------
// IDLE  | ready for a request; latches operands on handshake
// EXEC  | settle cycle for the ALU copies
// CMP   | compare copies; retry, or capture the response
// RESP  | response valid and held until the consumer takes it
// ---------------------------------------------------------------------------
module alu_lockstep_sequencer #(
   parameter int DATA_W    = 8,
   parameter int MAX_RETRY = 3,
   parameter int CNT_W     = 8
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_ni,
`ifdef ALU_LOCKSTEP_INJECT_EN
   input  logic              inj_en,
   input  logic [DATA_W-1:0] inj_mask,
`endif
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DATA_W-1:0] req_a,
   input  logic [DATA_W-1:0] req_b,
   input  logic [1:0]        req_sel,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [1:0]        alu_sel,
   input  logic [DATA_W-1:0] alu0_out,
   input  logic              alu0_carry,
   input  logic [DATA_W-1:0] alu1_out,
   input  logic              alu1_carry,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_carry,
   output logic              resp_fault,
   output logic [3:0]        resp_retries,
   output logic [CNT_W-1:0]  fault_cnt,
   output logic              fault_sticky,
   input  logic              clr_fault
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_CMP  = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   localparam logic [3:0] MAX_R = 4'(MAX_RETRY);

   state_t            state;
   state_t            state_nxt;
   logic [3:0]        retry_cnt;
   logic [DATA_W-1:0] alu1_cmp;
   logic              match;
   logic              retry_ok;
   logic              accept;
   logic              retry;
   logic              finish;
   logic              fault_inc;
   logic              fault_set;

`ifdef ALU_LOCKSTEP_INJECT_EN
   assign alu1_cmp = alu1_out ^ (inj_en ? inj_mask : '0);
`else
   assign alu1_cmp = alu1_out;
`endif

   assign match    = (alu0_out == alu1_cmp) && (alu0_carry == alu1_carry);
   assign retry_ok = (retry_cnt < MAX_R);

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) state <= ST_IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (req_valid)  state_nxt = ST_EXEC;
         ST_EXEC:                 state_nxt = ST_CMP;
         ST_CMP:  state_nxt = (!match && retry_ok) ? ST_EXEC : ST_RESP;
         ST_RESP: if (resp_ready) state_nxt = ST_IDLE;
         default:                 state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state == ST_IDLE);
      resp_valid = (state == ST_RESP);
      accept     = (state == ST_IDLE) && req_valid;
      retry      = (state == ST_CMP) && !match && retry_ok;
      finish     = (state == ST_CMP) && (match || !retry_ok);
      fault_inc  = (state == ST_CMP) && !match;
      fault_set  = (state == ST_CMP) && !match && !retry_ok;
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         alu_a        <= '0;
         alu_b        <= '0;
         alu_sel      <= '0;
         retry_cnt    <= '0;
         resp_data    <= '0;
         resp_carry   <= 1'b0;
         resp_fault   <= 1'b0;
         fault_cnt    <= '0;
         fault_sticky <= 1'b0;
      end else begin
         if (accept) begin
            alu_a     <= req_a;
            alu_b     <= req_b;
            alu_sel   <= req_sel;
            retry_cnt <= '0;
         end
         if (retry) retry_cnt <= retry_cnt + 4'd1;
         if (finish) begin
            resp_data  <= alu0_out;
            resp_carry <= alu0_carry;
            resp_fault <= !match;
         end
         // A clear in the same cycle as a compare drops that compare's count.
         if (clr_fault)                    fault_cnt <= '0;
         else if (fault_inc && !(&fault_cnt)) fault_cnt <= fault_cnt + 1'b1;
         // A new fault outranks a simultaneous clear.
         if (fault_set)      fault_sticky <= 1'b1;
         else if (clr_fault) fault_sticky <= 1'b0;
      end
   end

   assign resp_retries = retry_cnt;

endmodule
